// File: rtl/seg_anim_controller.sv
// Purpose: commanded sequencer driving one active-low 7-segment display from slow pin commands.
// Latency: command effect registered 2 edges after cmd_valid is first sampled; seg_n lags pos/mode by 1 cycle.
// Backpressure: none; one command per cmd_valid rising edge, a held-high strobe is not repeated.
// Ports: clk, reset (async active-low); cmd_valid/cmd/data command pins (cmd_valid asynchronous);
//        seg_n segment drive (bit0..7 = a..g,dp, active-low), tick advance pulse, running = RUN state.
module seg_anim_controller #(
    parameter int COUNTER_WIDTH = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    input  logic [3:0] data,
    output logic [7:0] seg_n,
    output logic       tick,
    output logic       running
);

    typedef enum logic {ST_PAUSE = 1'b0, ST_RUN = 1'b1} state_t;
    typedef enum logic [1:0] {M_SPIN_CW = 2'd0, M_SPIN_CCW = 2'd1, M_HEX = 2'd2, M_BLINK = 2'd3} mode_t;

    localparam logic [1:0] OP_SPEED = 2'b01;
    localparam logic [1:0] OP_MODE  = 2'b10;
    localparam logic [1:0] OP_CTRL  = 2'b11;
    localparam logic [COUNTER_WIDTH-5:0] LOW_ONES = '1;

    state_t                   state, state_nx;
    mode_t                    mode, mode_nx;
    logic [3:0]               speed, speed_nx;
    logic [3:0]               pos, pos_nx;
    logic [COUNTER_WIDTH-1:0] presc, presc_nx;
    logic [COUNTER_WIDTH-1:0] threshold;
    logic                     s1, s2, s3;
    logic                     accept;
    logic                     match;
    logic                     adv;
    logic                     clear_pos;
    logic [7:0]               pattern;

    // s1/s2 resynchronise the pin, s3 remembers the previous level for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= cmd_valid;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign accept    = s2 & ~s3;
    assign threshold = {speed, LOW_ONES};
    assign running   = (state == ST_RUN);

    // Next-state: prescaler advance first, then an accepted command overrides it
    always_comb begin
        state_nx  = state;
        mode_nx   = mode;
        speed_nx  = speed;
        pos_nx    = pos;
        clear_pos = 1'b0;
        match     = (state == ST_RUN) && (presc == threshold);
        adv       = match;
        if (state == ST_RUN) begin
            presc_nx = match ? '0 : presc + COUNTER_WIDTH'(1);
        end else begin
            presc_nx = presc;
        end

        if (accept) begin
            case (cmd)
                OP_SPEED: begin
                    speed_nx = data;
                    presc_nx = '0;
                    adv      = 1'b0;
                end
                OP_MODE: begin
                    mode_nx   = mode_t'(data[1:0]);
                    presc_nx  = '0;
                    adv       = 1'b0;
                    clear_pos = 1'b1;
                end
                OP_CTRL: begin
                    state_nx = data[0] ? ST_RUN : ST_PAUSE;
                    // only a step into PAUSE advances; a pending prescaler match is dropped
                    adv      = ~data[0] & data[1];
                end
                default: ;
            endcase
        end

        if (clear_pos) begin
            pos_nx = 4'd0;
        end else if (adv) begin
            case (mode)
                M_SPIN_CW:  pos_nx = {pos[3], pos[2:0] + 3'd1};
                M_SPIN_CCW: pos_nx = {pos[3], pos[2:0] - 3'd1};
                M_HEX:      pos_nx = pos + 4'd1;
                default:    pos_nx = {pos[3:1], ~pos[0]};
            endcase
        end
    end

    // Active-high segment pattern for the current pos/mode
    always_comb begin
        pattern = 8'h00;
        case (mode)
            M_SPIN_CW, M_SPIN_CCW: begin
                // figure-eight path shared by both directions
                case (pos[2:0])
                    3'd0:    pattern = 8'h01;
                    3'd1:    pattern = 8'h02;
                    3'd2:    pattern = 8'h40;
                    3'd3:    pattern = 8'h10;
                    3'd4:    pattern = 8'h08;
                    3'd5:    pattern = 8'h04;
                    3'd6:    pattern = 8'h40;
                    default: pattern = 8'h20;
                endcase
            end
            M_HEX: begin
                case (pos)
                    4'h0:    pattern = 8'h3F;
                    4'h1:    pattern = 8'h06;
                    4'h2:    pattern = 8'h5B;
                    4'h3:    pattern = 8'h4F;
                    4'h4:    pattern = 8'h66;
                    4'h5:    pattern = 8'h6D;
                    4'h6:    pattern = 8'h7D;
                    4'h7:    pattern = 8'h07;
                    4'h8:    pattern = 8'h7F;
                    4'h9:    pattern = 8'h6F;
                    4'hA:    pattern = 8'h77;
                    4'hB:    pattern = 8'h7C;
                    4'hC:    pattern = 8'h39;
                    4'hD:    pattern = 8'h5E;
                    4'hE:    pattern = 8'h79;
                    default: pattern = 8'h71;
                endcase
            end
            default: pattern = pos[0] ? 8'h00 : 8'hFF;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_RUN;
            mode  <= M_SPIN_CW;
            speed <= 4'hF;
            pos   <= 4'd0;
            presc <= '0;
            seg_n <= 8'hFF;
            tick  <= 1'b0;
        end else begin
            state <= state_nx;
            mode  <= mode_nx;
            speed <= speed_nx;
            pos   <= pos_nx;
            presc <= presc_nx;
            seg_n <= ~pattern;
            tick  <= adv;
        end
    end

endmodule

// File: tb/tb_seg_anim_controller.sv
// Purpose: randomized + directed bench for seg_anim_controller against a cycle-level behavioural model.
// Latency: outputs compared 1 time unit after every rising clk edge.
// Backpressure: none; commands are spaced so only one is in flight at a time.
module tb_seg_anim_controller;

    localparam int CW = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd = 2'b00;
    logic [3:0] data = 4'h0;
    logic [7:0] seg_n;
    logic       tick;
    logic       running;

    seg_anim_controller #(.COUNTER_WIDTH(CW)) dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_valid(cmd_valid),
        .cmd      (cmd),
        .data     (data),
        .seg_n    (seg_n),
        .tick     (tick),
        .running  (running)
    );

    always #5 clk = ~clk;

    localparam logic [7:0] SPIN_T [8]  = '{8'h01, 8'h02, 8'h40, 8'h10, 8'h08, 8'h04, 8'h40, 8'h20};
    localparam logic [7:0] HEX_T  [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                          8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;

    // behavioural model state
    int       m_speed, m_mode, m_pos, m_presc;
    bit       m_run, m_tick;
    bit [7:0] m_seg;
    int       pend_edge, pend_cmd, pend_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    function automatic bit [7:0] pat(input int pos, input int mode);
        case (mode)
            0, 1:    return SPIN_T[pos % 8];
            2:       return HEX_T[pos % 16];
            default: return (pos % 2 == 0) ? 8'hFF : 8'h00;
        endcase
    endfunction

    function automatic void model_reset();
        m_speed = 15; m_mode = 0; m_pos = 0; m_presc = 0;
        m_run = 1; m_tick = 0; m_seg = 8'hFF; pend_edge = -1;
    endfunction

    // Effect of one clock edge on the model
    function automatic void model_edge();
        int  period_thr;
        int  np;
        bit  adv;
        if (!reset) begin
            model_reset();
            return;
        end
        period_thr = m_speed * (1 << (CW - 4)) + (1 << (CW - 4)) - 1;
        adv = m_run && (m_presc == period_thr);
        np  = !m_run ? m_presc : (adv ? 0 : m_presc + 1);
        m_seg = ~pat(m_pos, m_mode);
        if (pend_edge == edge_n) begin
            pend_edge = -1;
            case (pend_cmd)
                1: begin m_speed = pend_data; np = 0; adv = 0; end
                2: begin m_mode = pend_data % 4; m_pos = 0; np = 0; adv = 0; end
                3: begin
                    m_run = pend_data[0];
                    adv   = !pend_data[0] && pend_data[1];
                end
                default: ;
            endcase
        end
        if (adv) begin
            case (m_mode)
                0:       m_pos = (m_pos / 8) * 8 + (m_pos + 1) % 8;
                1:       m_pos = (m_pos / 8) * 8 + (m_pos + 7) % 8;
                2:       m_pos = (m_pos + 1) % 16;
                default: m_pos = m_pos ^ 1;
            endcase
        end
        m_presc = np;
        m_tick  = adv;
    endfunction

    task automatic step();
        @(posedge clk);
        edge_n++;
        model_edge();
        #1;
        chk("seg_n", seg_n, m_seg);
        chk("tick", tick, m_tick);
        chk("running", running, m_run);
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) step();
    endtask

    // cmd_valid rises after edge n, so it is first sampled at n+1 and takes effect at n+3
    task automatic send(input int c, input int d, input int hold);
        cmd       = 2'(c);
        data      = 4'(d);
        cmd_valid = 1'b1;
        pend_edge = edge_n + 3;
        pend_cmd  = c;
        pend_data = d;
        run(hold);
        cmd_valid = 1'b0;
        run(4);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int thr;
        model_reset();
        #12;
        chk("rst_seg", seg_n, 8'hFF);
        chk("rst_tick", tick, 1'b0);
        chk("rst_running", running, 1'b1);
        @(negedge clk);
        reset = 1'b1;

        // default speed: 64-cycle advances
        run(200);
        // speed 1: 8-cycle advances, full spin wrap
        send(1, 1, 1);
        run(150);
        // hex through F and wrap
        send(2, 2, 2);
        run(150);
        // counter-clockwise from pos 0
        send(2, 1, 1);
        run(30);
        // pause, step, run+step
        send(3, 0, 1);
        run(100);
        chk("pause_running", running, 1'b0);
        send(3, 2, 1);
        run(20);
        send(3, 3, 1);
        run(30);
        // held strobe: single accept
        send(1, 3, 50);
        run(60);
        // SPEED accept lands on a prescaler match
        thr = 3 * 4 + 3;
        for (int i = 0; i < 100 && !(m_run && m_presc == thr - 2); i++) step();
        chk("collide_setup", m_presc, thr - 2);
        send(1, 1, 1);
        run(30);

        // random commands
        for (int it = 0; it < 40; it++) begin
            send($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(1, 8));
            run($urandom_range(0, 40));
        end

        // async reset mid-BLINK with a command in the synchronizer
        send(3, 1, 1);
        send(1, 0, 1);
        send(2, 3, 1);
        run(20);
        cmd       = 2'b01;
        data      = 4'h1;
        cmd_valid = 1'b1;
        pend_edge = edge_n + 3;
        pend_cmd  = 1;
        pend_data = 1;
        step();
        #2;
        reset = 1'b0;
        #1;
        chk("arst_seg", seg_n, 8'hFF);
        chk("arst_tick", tick, 1'b0);
        chk("arst_running", running, 1'b1);
        model_reset();
        cmd_valid = 1'b0;
        run(3);
        @(negedge clk);
        reset = 1'b1;
        run(200);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
